bus_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the single-bus register datapath (R0–R7, A, ALU, G, data tri-buffer). It fetches 23-bit instruction words from the combinational program ROM. It decodes each word and drives, one bus step per cycle, the tri-buffer enables, register load enables, A/G controls and one-hot ALU function select. It replaces the ad-hoc FSM plus separate address register, and owns the program counter directly.

---
 rtl/bus_sequencer.sv | 176 +++++++++++++++++
 tb/tb_bus_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// Fetch/decode/execute controller for the single-bus register datapath.
// Owns the program counter; every control strobe is registered.
module bus_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [22:0] code,
  output logic [4:0]  address,
  output logic [15:0] d,
  output logic        data_out,
  output logic [7:0]  bus_buf_en,
  output logic [7:0]  reg_en,
  output logic        a_in,
  output logic        g_in,
  output logic        g_out,
  output logic [6:0]  math_enables,
  output logic        busy,
  output logic        halted,
  output logic        retire
);

  // state | meaning
  // IDLE  | parked, no strobes; leaves when run=1
  // FETCH | IR<-code, pc<-pc+1
  // EX1   | first bus step (LOAD/MOVE/JMP/NOP retire here)
  // EX2   | ALU: Ry onto bus, G<-A op bus
  // EX3   | ALU: G onto bus, Rx<-bus, retire
  // HALT  | frozen until reset
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EX1, S_EX2, S_EX3, S_HALT
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_MOVE = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_MOD  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state;
  logic [4:0]  pc;
  logic [3:0]  ir_op;
  logic [2:0]  ir_rx;
  logic [2:0]  ir_ry;
  logic [4:0]  ir_tgt;

  logic [3:0]  c_op;
  logic [2:0]  c_rx;
  logic [2:0]  c_ry;
  logic [15:0] c_imm;

  assign c_op    = code[22:19];
  assign c_rx    = code[18:16];
  assign c_ry    = code[15:13];
  assign c_imm   = code[15:0];
  assign address = pc;

  // Register strobes are numbered with R0 in the MSB.
  function automatic logic [7:0] reg_sel(input logic [2:0] idx);
    return 8'h80 >> idx;
  endfunction

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOD);
  endfunction

  function automatic logic [6:0] alu_sel(input logic [3:0] op);
    return 7'b100_0000 >> (op - OP_ADD);
  endfunction

  // Outputs are loaded with the values for the state being entered,
  // so the EX1 strobes are decoded from the word as it lands in IR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc           <= '0;
      ir_op        <= '0;
      ir_rx        <= '0;
      ir_ry        <= '0;
      ir_tgt       <= '0;
      d            <= '0;
      data_out     <= 1'b0;
      bus_buf_en   <= '0;
      reg_en       <= '0;
      a_in         <= 1'b0;
      g_in         <= 1'b0;
      g_out        <= 1'b0;
      math_enables <= '0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      retire       <= 1'b0;
    end else begin
      d            <= '0;
      data_out     <= 1'b0;
      bus_buf_en   <= '0;
      reg_en       <= '0;
      a_in         <= 1'b0;
      g_in         <= 1'b0;
      g_out        <= 1'b0;
      math_enables <= '0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      retire       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          ir_op  <= c_op;
          ir_rx  <= c_rx;
          ir_ry  <= c_ry;
          ir_tgt <= c_imm[4:0];
          pc     <= pc + 5'd1;
          state  <= S_EX1;
          busy   <= 1'b1;
          if (c_op == OP_LOAD) begin
            data_out <= 1'b1;
            d        <= c_imm;
            reg_en   <= reg_sel(c_rx);
            retire   <= 1'b1;
          end else if (c_op == OP_MOVE) begin
            bus_buf_en <= reg_sel(c_rx);
            reg_en     <= reg_sel(c_ry);
            retire     <= 1'b1;
          end else if (is_alu(c_op)) begin
            bus_buf_en <= reg_sel(c_rx);
            a_in       <= 1'b1;
          end else if (c_op != OP_HALT) begin
            retire <= 1'b1;
          end
        end
        S_EX1: begin
          if (ir_op == OP_JMP) pc <= ir_tgt;
          if (is_alu(ir_op)) begin
            state        <= S_EX2;
            busy         <= 1'b1;
            bus_buf_en   <= reg_sel(ir_ry);
            math_enables <= alu_sel(ir_op);
            g_in         <= 1'b1;
          end else if (ir_op == OP_HALT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (run) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_EX2: begin
          state  <= S_EX3;
          busy   <= 1'b1;
          g_out  <= 1'b1;
          reg_en <= reg_sel(ir_rx);
          retire <= 1'b1;
        end
        S_EX3: begin
          if (run) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: ROM + datapath model, cycle table for one program,
// write scoreboard, and directed sequences for jump/wrap, run, halt and reset.
module tb_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [22:0] code;
  logic [4:0]  address;
  logic [15:0] d;
  logic        data_out;
  logic [7:0]  bus_buf_en;
  logic [7:0]  reg_en;
  logic        a_in;
  logic        g_in;
  logic        g_out;
  logic [6:0]  math_enables;
  logic        busy;
  logic        halted;
  logic        retire;

  bus_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .code(code), .address(address),
    .d(d), .data_out(data_out), .bus_buf_en(bus_buf_en), .reg_en(reg_en),
    .a_in(a_in), .g_in(g_in), .g_out(g_out), .math_enables(math_enables),
    .busy(busy), .halted(halted), .retire(retire)
  );

  always #5 clk = ~clk;

  logic [22:0] rom [32];
  assign code = rom[address];

  typedef struct {
    logic        run;
    logic [4:0]  addr;
    logic        dout;
    logic [15:0] d;
    logic [7:0]  bbe;
    logic [7:0]  ren;
    logic        ain;
    logic        gin;
    logic        gout;
    logic [6:0]  math;
    logic        busy;
    logic        halted;
    logic        retire;
  } vec_t;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] val;
  } wr_t;

  localparam logic [22:0] I_NOP  = 23'd0;
  localparam logic [22:0] I_HALT = {4'hF, 19'd0};

  vec_t        tbl[$];
  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] r [8];
  logic [15:0] a_reg;
  logic [15:0] g_reg;
  logic [15:0] mon_bus;
  int          mon_drv;
  logic [2:0]  mon_idx;
  wr_t         mon_e;
  int          exp_addr [8];

  function automatic vec_t v(input int run_i, input int a, input int o, input int dd,
                             input int b, input int re, input int ai, input int gi,
                             input int go, input int m, input int bz, input int h,
                             input int rt);
    vec_t x;
    x.run = 1'(run_i); x.addr = 5'(a); x.dout = 1'(o); x.d = 16'(dd);
    x.bbe = 8'(b); x.ren = 8'(re); x.ain = 1'(ai); x.gin = 1'(gi);
    x.gout = 1'(go); x.math = 7'(m); x.busy = 1'(bz); x.halted = 1'(h);
    x.retire = 1'(rt);
    return x;
  endfunction

  function automatic logic [50:0] pack(input vec_t x);
    return {x.addr, x.d, x.dout, x.bbe, x.ren, x.ain, x.gin, x.gout, x.math,
            x.busy, x.halted, x.retire};
  endfunction

  function logic [50:0] act_vec();
    return {address, d, data_out, bus_buf_en, reg_en, a_in, g_in, g_out,
            math_enables, busy, halted, retire};
  endfunction

  function automatic logic [22:0] i_load(input int rx, input int imm);
    return {4'h1, 3'(rx), 16'(imm)};
  endfunction

  function automatic logic [22:0] i_rr(input int op, input int rx, input int ry);
    return {4'(op), 3'(rx), 3'(ry), 13'd0};
  endfunction

  function automatic logic [22:0] i_jmp(input int t);
    return {4'hA, 3'd0, 11'd0, 5'(t)};
  endfunction

  function automatic logic [15:0] ref_alu(input int op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      3: return x + y;
      4: return x - y;
      5: return x ^ y;
      6: return x & y;
      7: return x | y;
      8: return (y == 0) ? 16'd0 : x / y;
      9: return (y == 0) ? 16'd0 : x % y;
      default: return 16'd0;
    endcase
  endfunction

  // Datapath ALU driven by the DUT's one-hot select, not by the opcode.
  function automatic logic [15:0] model_alu(input logic [6:0] m, input logic [15:0] x, input logic [15:0] y);
    case (m)
      7'b1000000: return x + y;
      7'b0100000: return x - y;
      7'b0010000: return x ^ y;
      7'b0001000: return x & y;
      7'b0000100: return x | y;
      7'b0000010: return (y == 0) ? 16'd0 : x / y;
      7'b0000001: return (y == 0) ? 16'd0 : x % y;
      default:    return 16'hDEAD;
    endcase
  endfunction

  task automatic chk_vec(input string name, input logic [50:0] act, input logic [50:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic exp_wr(input int idx, input int val);
    wr_t e;
    e.idx = 3'(idx);
    e.val = 16'(val);
    exp_q.push_back(e);
  endtask

  task automatic chk_q(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d register writes still outstanding, expected 0", name, exp_q.size());
    end
  endtask

  // Bus model and write scoreboard, evaluated once per cycle mid-period.
  task monitor();
    mon_bus = 16'd0;
    mon_drv = int'(data_out) + int'(g_out) + $countones(bus_buf_en);
    if (data_out) mon_bus = d;
    if (g_out) mon_bus = g_reg;
    for (int k = 0; k < 8; k++) if (bus_buf_en[7-k]) mon_bus = r[k];
    n_checks++;
    if (mon_drv > 1 || (!data_out && d != 16'd0)) begin
      n_fail++;
      $display("FAIL bus_drivers: drivers=%0d data_out=%b d=%h, expected <=1 driver and d=0 when idle",
               mon_drv, data_out, d);
    end
    if (reg_en != 8'd0) begin
      n_checks++;
      mon_idx = 3'd0;
      for (int k = 0; k < 8; k++) if (reg_en[7-k]) mon_idx = 3'(k);
      if ($countones(reg_en) != 1 || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL reg_write: unexpected reg_en=%b value=%h, expected no write", reg_en, mon_bus);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.idx != mon_idx || mon_e.val != mon_bus) begin
          n_fail++;
          $display("FAIL reg_write: got R%0d=%h expected R%0d=%h", mon_idx, mon_bus, mon_e.idx, mon_e.val);
        end
      end
      r[mon_idx] = mon_bus;
    end
    if (a_in) a_reg = mon_bus;
    if (g_in) g_reg = model_alu(math_enables, a_reg, mon_bus);
  endtask

  task tick();
    @(negedge clk);
    monitor();
  endtask

  task do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task rom_clear();
    for (int k = 0; k < 32; k++) rom[k] = I_NOP;
  endtask

  task automatic wait_halt(input int max, input string name);
    int n = 0;
    while (halted !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk16(name, 16'(halted), 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 8; k++) r[k] = 16'd0;
    a_reg = 16'd0;
    g_reg = 16'd0;

    // Cycle table: LOAD x3, ADD, MOVE, JMP over dead code, reserved op, HALT.
    rom_clear();
    rom[0] = i_load(3, 'hA5);
    rom[1] = i_load(1, 7);
    rom[2] = i_load(2, 5);
    rom[3] = i_rr(3, 1, 2);
    rom[4] = i_rr(2, 1, 6);
    rom[5] = i_jmp(9);
    rom[6] = i_load(0, 'hDEAD);
    rom[7] = i_load(0, 'hDEAD);
    rom[8] = i_load(0, 'hDEAD);
    rom[9] = {4'hC, 19'd0};
    rom[10] = I_HALT;
    exp_wr(3, 'hA5); exp_wr(1, 7); exp_wr(2, 5); exp_wr(1, 12); exp_wr(6, 12);
    //              run adr o  d     bbe   ren   ai gi go math bz h  rt
    tbl.push_back(v(1,  0,  0, 0,    0,    0,    0, 0, 0, 0,   0, 0, 0));
    tbl.push_back(v(1,  0,  0, 0,    0,    0,    0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(v(1,  1,  1, 'hA5, 0,    'h10, 0, 0, 0, 0,   1, 0, 1));
    tbl.push_back(v(1,  1,  0, 0,    0,    0,    0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(v(1,  2,  1, 7,    0,    'h40, 0, 0, 0, 0,   1, 0, 1));
    tbl.push_back(v(1,  2,  0, 0,    0,    0,    0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(v(1,  3,  1, 5,    0,    'h20, 0, 0, 0, 0,   1, 0, 1));
    tbl.push_back(v(1,  3,  0, 0,    0,    0,    0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(v(1,  4,  0, 0,    'h40, 0,    1, 0, 0, 0,   1, 0, 0));
    tbl.push_back(v(1,  4,  0, 0,    'h20, 0,    0, 1, 0, 'h40,1, 0, 0));
    tbl.push_back(v(1,  4,  0, 0,    0,    'h40, 0, 0, 1, 0,   1, 0, 1));
    tbl.push_back(v(1,  4,  0, 0,    0,    0,    0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(v(1,  5,  0, 0,    'h40, 'h02, 0, 0, 0, 0,   1, 0, 1));
    tbl.push_back(v(1,  5,  0, 0,    0,    0,    0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(v(1,  6,  0, 0,    0,    0,    0, 0, 0, 0,   1, 0, 1));
    tbl.push_back(v(1,  9,  0, 0,    0,    0,    0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(v(1,  10, 0, 0,    0,    0,    0, 0, 0, 0,   1, 0, 1));
    tbl.push_back(v(1,  10, 0, 0,    0,    0,    0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(v(1,  11, 0, 0,    0,    0,    0, 0, 0, 0,   1, 0, 0));
    tbl.push_back(v(1,  11, 0, 0,    0,    0,    0, 0, 0, 0,   0, 1, 0));
    tbl.push_back(v(1,  11, 0, 0,    0,    0,    0, 0, 0, 0,   0, 1, 0));
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) tick();
      chk_vec($sformatf("table_c%0d", i), act_vec(), pack(tbl[i]));
      run = tbl[i].run;
    end
    chk16("table_r3", r[3], 16'h00A5);
    chk16("table_r1", r[1], 16'd12);
    chk16("table_r2", r[2], 16'd5);
    chk16("table_r6", r[6], 16'd12);
    chk16("table_r0", r[0], 16'd0);
    chk_q("table_queue");

    // Every ALU function through the full datapath.
    for (int op = 3; op <= 9; op++) begin
      rom_clear();
      rom[0] = i_load(1, 20);
      rom[1] = i_load(2, 6);
      rom[2] = i_rr(op, 1, 2);
      rom[3] = I_HALT;
      exp_wr(1, 20); exp_wr(2, 6); exp_wr(1, ref_alu(op, 16'd20, 16'd6));
      do_reset();
      run = 1'b1;
      wait_halt(40, $sformatf("alu%0d_halt", op));
      chk16($sformatf("alu%0d_result", op), r[1], ref_alu(op, 16'd20, 16'd6));
      chk_q($sformatf("alu%0d_queue", op));
    end

    // Jump to 31, wrap to 0, then jump to 5.
    rom_clear();
    rom[0] = i_jmp(31);
    rom[5] = I_HALT;
    exp_addr = '{0, 1, 31, 0, 0, 1, 5, 6};
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk16($sformatf("wrap_addr_c%0d", i + 1), 16'(address), 16'(exp_addr[i]));
      if (i == 1) rom[0] = i_jmp(5);
    end
    tick();
    chk16("wrap_halted", 16'(halted), 16'd1);

    // run dropped during EX2 of SUB, later resumed.
    rom_clear();
    rom[0] = i_load(4, 9);
    rom[1] = i_load(5, 4);
    rom[2] = i_rr(4, 4, 5);
    rom[3] = i_load(7, 'h33);
    rom[4] = I_HALT;
    exp_wr(4, 9); exp_wr(5, 4); exp_wr(4, 5); exp_wr(7, 'h33);
    do_reset();
    run = 1'b1;
    repeat (7) tick();
    chk16("runctl_in_ex2", 16'(g_in), 16'd1);
    run = 1'b0;
    tick();
    chk16("runctl_ex3", 16'({g_out, retire}), 16'd3);
    tick();
    chk_vec("runctl_idle", act_vec(), pack(v(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tick();
    tick();
    chk_vec("runctl_idle_hold", act_vec(), pack(v(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    run = 1'b1;
    tick();
    chk16("runctl_resume", 16'({address, busy}), 16'({5'd3, 1'b1}));
    wait_halt(20, "runctl_halt");
    chk16("runctl_r4", r[4], 16'd5);
    chk16("runctl_r7", r[7], 16'h0033);
    chk_q("runctl_queue");

    // HALT holds with run high until reset.
    rom_clear();
    rom[0] = i_load(0, 1);
    rom[2] = I_HALT;
    exp_wr(0, 1);
    do_reset();
    run = 1'b1;
    wait_halt(20, "halt_reach");
    for (int i = 0; i < 20; i++) begin
      chk_vec($sformatf("halt_hold_%0d", i), act_vec(), pack(v(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
      tick();
    end
    do_reset();
    chk_vec("halt_reset", act_vec(), 51'd0);
    chk_q("halt_queue");

    // Reset taken at the edge ending EX2 of SUB R4,R5.
    rom_clear();
    rom[0] = i_load(4, 9);
    rom[1] = i_load(5, 4);
    rom[2] = i_rr(4, 4, 5);
    rom[3] = i_load(7, 'h33);
    rom[4] = I_HALT;
    exp_wr(4, 9); exp_wr(5, 4);
    do_reset();
    run = 1'b1;
    repeat (7) tick();
    chk16("rstmid_in_ex2", 16'(g_in), 16'd1);
    rst_n = 1'b0;
    tick();
    chk_vec("rstmid_zero", act_vec(), 51'd0);
    rst_n = 1'b1;
    run = 1'b0;
    tick();
    chk_vec("rstmid_idle", act_vec(), 51'd0);
    chk_q("rstmid_queue");
    exp_wr(4, 9);
    run = 1'b1;
    tick();
    chk16("rstmid_fetch_pc0", 16'({address, busy}), 16'({5'd0, 1'b1}));
    run = 1'b0;
    tick();
    tick();
    chk_vec("rstmid_after", act_vec(), pack(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    chk_q("rstmid_queue_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
